// File: rtl/multicycle_control.sv
// multicycle_control
//   Control FSM for a multicycle RV32I-subset core. Sequences
//   IF -> ID -> EX -> (MEM) -> (WB), decodes the captured instruction
//   into the 4-bit ALU op in EX, and handshakes with the instruction
//   and data memories.
// Ports:
//   clk, rst          clock / asynchronous active-high reset
//   instr             instruction word from instruction memory
//   imem_ready        instr valid this cycle (captured in IF)
//   dmem_ready        data access completes this cycle
//   zero              ALU zero flag (branch resolution in EX)
//   alu_op, alu_src   ALU op code and op2 select (1 = immediate)
//   load_instr        IR / PC-hold capture strobe (asserted in IF)
//   mem_read/write    data memory requests (MEM)
//   mem_to_reg        writeback source is memory data
//   reg_write         register file write enable (WB)
//   pc_update, pc_src PC load enable / 1 = branch target
//   illegal           one-cycle pulse in EX for unsupported encodings
module multicycle_control #(
  parameter logic [3:0] ALU_AND = 4'b0000,
  parameter logic [3:0] ALU_OR  = 4'b0001,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110,
  parameter logic [3:0] ALU_SLT = 4'b0100,
  parameter logic [3:0] ALU_SRL = 4'b1000,
  parameter logic [3:0] ALU_SLL = 4'b1001,
  parameter logic [3:0] ALU_SRA = 4'b1010,
  parameter logic [3:0] ALU_XOR = 4'b0101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        zero,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        load_instr,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        pc_update,
  output logic        pc_src,
  output logic        illegal
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  logic [2:0]  state, state_nxt;
  logic [31:0] ir;

  // ---------------- decode of the captured instruction ----------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_lw, is_sw, is_beq;
  logic [3:0] dec_op;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];

  // funct3 011 (sltu/sltiu) is outside the supported subset.
  assign is_r   = (opcode == 7'b0110011) && (funct3 != 3'b011);
  assign is_i   = (opcode == 7'b0010011) && (funct3 != 3'b011);
  assign is_lw  = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw  = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_beq = (opcode == 7'b1100011) && (funct3 == 3'b000);

  // IR bits that never influence control; kept as a full 32-bit IR.
  logic unused_ir;
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  // Shared R/I funct3 map; IR[30] selects SUB only for R-type, while
  // SRA/SRL uses IR[30] for both forms.
  always_comb begin
    dec_op = ALU_ADD;
    case (funct3)
      3'b000:  dec_op = (is_r && ir[30]) ? ALU_SUB : ALU_ADD;
      3'b111:  dec_op = ALU_AND;
      3'b110:  dec_op = ALU_OR;
      3'b100:  dec_op = ALU_XOR;
      3'b010:  dec_op = ALU_SLT;
      3'b001:  dec_op = ALU_SLL;
      3'b101:  dec_op = ir[30] ? ALU_SRA : ALU_SRL;
      default: dec_op = ALU_ADD;
    endcase
  end

  // ---------------- state register + IR ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IF;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IF && imem_ready) ir <= instr;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF:  state_nxt = imem_ready ? S_ID : S_IF;
      S_ID:  state_nxt = S_EX;
      S_EX: begin
        if (is_r || is_i)        state_nxt = S_WB;
        else if (is_lw || is_sw) state_nxt = S_MEM;
        else                     state_nxt = S_IF;
      end
      // Only LW/SW reach MEM; a store retires here, a load goes to WB.
      S_MEM: begin
        if (!dmem_ready) state_nxt = S_MEM;
        else             state_nxt = is_lw ? S_WB : S_IF;
      end
      S_WB:    state_nxt = S_IF;
      default: state_nxt = S_IF;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    load_instr = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_update  = 1'b0;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_IF: load_instr = 1'b1;
      S_ID: ;
      S_EX: begin
        if (is_r) begin
          alu_op = dec_op;
        end else if (is_i) begin
          alu_op  = dec_op;
          alu_src = 1'b1;
        end else if (is_lw || is_sw) begin
          alu_src = 1'b1;
        end else if (is_beq) begin
          alu_op    = ALU_SUB;
          pc_update = 1'b1;
          pc_src    = zero;
        end else begin
          illegal   = 1'b1;
          pc_update = 1'b1;
        end
      end
      S_MEM: begin
        mem_read  = is_lw;
        mem_write = is_sw;
        pc_update = is_sw && dmem_ready;
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_update  = 1'b1;
        mem_to_reg = is_lw;
      end
      // Unencoded states look like reset for the one cycle they last.
      default: load_instr = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0100, OP_SRL = 4'b1000,
                         OP_SLL = 4'b1001, OP_SRA = 4'b1010, OP_XOR = 4'b0101;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        imem_ready, dmem_ready, zero;
  logic [3:0]  alu_op;
  logic        alu_src, load_instr, mem_read, mem_write, mem_to_reg;
  logic        reg_write, pc_update, pc_src, illegal;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .zero(zero), .alu_op(alu_op), .alu_src(alu_src),
    .load_instr(load_instr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .pc_update(pc_update),
    .pc_src(pc_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected output vector per cycle, produced by the stimulus process.
  logic [12:0] exp_q[$];

  // Per-instruction schedule (inputs + expected outputs per cycle).
  logic [31:0] s_in[$];
  logic        s_ir[$], s_dr[$], s_z[$];
  logic [12:0] s_ex[$];

  function automatic logic [12:0] mk(logic [3:0] op, logic src, logic li,
      logic mr, logic mw, logic mtr, logic rw, logic pu, logic ps, logic il);
    return {op, src, li, mr, mw, mtr, rw, pu, ps, il};
  endfunction

  function automatic logic [12:0] got_vec();
    return {alu_op, alu_src, load_instr, mem_read, mem_write, mem_to_reg,
            reg_write, pc_update, pc_src, illegal};
  endfunction

  function automatic int kind_of(logic [31:0] i);
    logic [2:0] f3;
    f3 = i[14:12];
    case (i[6:0])
      7'b0110011: return (f3 == 3'b011) ? K_ILL : K_R;
      7'b0010011: return (f3 == 3'b011) ? K_ILL : K_I;
      7'b0000011: return (f3 == 3'b010) ? K_LW  : K_ILL;
      7'b0100011: return (f3 == 3'b010) ? K_SW  : K_ILL;
      7'b1100011: return (f3 == 3'b000) ? K_BEQ : K_ILL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] arith_op(logic [31:0] i, int k);
    logic [3:0] tbl [8];
    logic [3:0] r;
    tbl = '{OP_ADD, OP_SLL, OP_SLT, OP_ADD, OP_XOR, OP_SRL, OP_OR, OP_AND};
    r = tbl[i[14:12]];
    if (i[14:12] == 3'd0 && k == K_R && i[30]) r = OP_SUB;
    if (i[14:12] == 3'd5 && i[30])             r = OP_SRA;
    return r;
  endfunction

  task automatic add(input logic [31:0] i, input logic ir_, input logic dr,
                     input logic z, input logic [12:0] e);
    s_in.push_back(i); s_ir.push_back(ir_); s_dr.push_back(dr);
    s_z.push_back(z);  s_ex.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Build the per-cycle schedule from the spec rules, then drive it.
  // lit_len > 0 enables hand-computed checks of the EX op and cycle count.
  task automatic run_instr(input logic [31:0] ins, input int wi, input int wd,
                           input logic z, input logic [3:0] lit_op,
                           input int lit_len);
    int k, first_pu;
    logic [3:0] op;
    logic [12:0] idle;
    k  = kind_of(ins);
    op = arith_op(ins, k);
    idle = mk(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    s_in.delete(); s_ir.delete(); s_dr.delete(); s_z.delete(); s_ex.delete();
    for (int j = 0; j < wi; j++)
      add($urandom, 1'b0, 1'($urandom), 1'($urandom),
          mk(OP_ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add(ins, 1'b1, 1'($urandom), 1'($urandom), mk(OP_ADD, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add($urandom, 1'($urandom), 1'($urandom), 1'($urandom), idle);
    case (k)
      K_R:   add($urandom, 1'($urandom), 1'($urandom), z, mk(op, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      K_I:   add($urandom, 1'($urandom), 1'($urandom), z, mk(op, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      K_LW, K_SW:
             add($urandom, 1'($urandom), 1'($urandom), z, mk(OP_ADD, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      K_BEQ: add($urandom, 1'($urandom), 1'($urandom), z, mk(OP_SUB, 0, 0, 0, 0, 0, 0, 1, z, 0));
      default:
             add($urandom, 1'($urandom), 1'($urandom), z, mk(OP_ADD, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    endcase
    if (k == K_LW || k == K_SW) begin
      for (int j = 0; j <= wd; j++) begin
        logic last;
        last = (j == wd);
        add($urandom, 1'($urandom), last, 1'($urandom),
            mk(OP_ADD, 0, 0, k == K_LW, k == K_SW, 0, 0, (k == K_SW) && last, 0, 0));
      end
    end
    if (k == K_R || k == K_I || k == K_LW)
      add($urandom, 1'($urandom), 1'($urandom), 1'($urandom),
          mk(OP_ADD, 0, 0, 0, 0, k == K_LW, 1, 1, 0, 0));

    first_pu = -1;
    for (int c = 0; c < s_ex.size(); c++) begin
      @(posedge clk); #1;
      instr = s_in[c]; imem_ready = s_ir[c]; dmem_ready = s_dr[c]; zero = s_z[c];
      exp_q.push_back(s_ex[c]);
      @(negedge clk);
      if (lit_len > 0) begin
        if (c == wi + 2) chk("ex_alu_op", int'(alu_op), int'(lit_op));
        if (pc_update && first_pu < 0) first_pu = c + 1;
      end
    end
    if (lit_len > 0) chk("instr_cycles", first_pu, lit_len);
  endtask

  // Single compare process: every scheduled cycle is checked at negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e;
      e = exp_q.pop_front();
      total++;
      if (got_vec() !== e) begin
        bad++;
        $display("FAIL cycle_outputs got=%013b want=%013b at %0t", got_vec(), e, $time);
      end
    end
  end

  initial begin
    rst = 1'b1; instr = 32'h002081B3; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b0;
    #3;
    chk("rst_load_instr", load_instr, 1);
    chk("rst_alu_op", int'(alu_op), int'(OP_ADD));
    chk("rst_others", int'({alu_src, mem_read, mem_write, mem_to_reg, reg_write,
                            pc_update, pc_src, illegal}), 0);
    repeat (2) @(posedge clk);
    #2 chk("rst_hold_load_instr", load_instr, 1);
    imem_ready = 1'b0;
    @(negedge clk) rst = 1'b0;

    // Directed cases with hand-computed op codes and cycle counts.
    run_instr(32'h002081B3, 0, 0, 1'b0, OP_ADD, 4);  // add
    run_instr(32'h402081B3, 0, 0, 1'b0, OP_SUB, 4);  // sub
    run_instr(32'h4030D213, 0, 0, 1'b0, OP_SRA, 4);  // srai
    run_instr(32'h0080A283, 0, 3, 1'b0, OP_ADD, 8);  // lw, 3 wait states
    run_instr(32'h0050A423, 0, 0, 1'b0, OP_ADD, 4);  // sw
    run_instr(32'h00208463, 0, 0, 1'b1, OP_SUB, 3);  // beq taken
    run_instr(32'h00208463, 0, 0, 1'b0, OP_SUB, 3);  // beq not taken
    run_instr(32'h0000000B, 0, 0, 1'b0, OP_ADD, 3);  // unsupported opcode
    run_instr(32'h0020B1B3, 2, 0, 1'b0, OP_ADD, 0);  // sltu -> illegal, imem waits

    // Reset during an LW MEM wait.
    @(posedge clk); #1;
    instr = 32'h0080A283; imem_ready = 1'b1; dmem_ready = 1'b0;
    @(posedge clk); #1 imem_ready = 1'b0; instr = 32'h0;
    repeat (2) @(posedge clk);
    #2 chk("lw_wait_mem_read", mem_read, 1);
    rst = 1'b1; imem_ready = 1'b0;
    #1;
    chk("rst_mid_mem_read", mem_read, 0);
    chk("rst_mid_load_instr", load_instr, 1);
    chk("rst_mid_writes", int'({mem_write, reg_write, pc_update}), 0);
    @(posedge clk); #2;
    chk("rst_mid_held", int'({load_instr, mem_read}), 2);
    @(negedge clk) rst = 1'b0;

    // Randomized instruction mix with random memory wait states.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] ins;
      logic [6:0]  opc [6];
      logic [2:0]  nom [6];
      int sel;
      opc = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0};
      nom = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000};
      sel = $urandom_range(0, 5);
      ins = $urandom;
      ins[6:0] = (sel == 5) ? 7'($urandom) : opc[sel];
      if (sel >= 2 && sel <= 4 && ($urandom % 4 != 0)) ins[14:12] = nom[sel];
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), OP_ADD, 0);
    end

    @(posedge clk); @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle RISC-V (RV32I subset) control FSM. It is the producer side of the ALU op interface: it decodes the captured instruction, drives the 4-bit ALU operation code, and sequences the datapath through fetch, decode, execute, memory and writeback. It consumes the ALU zero flag for branch resolution and handshakes with instruction and data memory.

Parameters:
ALU_AND, 4'b0000, AND op code driven on alu_op
ALU_OR, 4'b0001, OR
ALU_ADD, 4'b0010, add (also the idle/default code)
ALU_SUB, 4'b0110, subtract
ALU_SLT, 4'b0100, signed less-than
ALU_SRL, 4'b1000, shift right logical
ALU_SLL, 4'b1001, shift left logical
ALU_SRA, 4'b1010, shift right arithmetic
ALU_XOR, 4'b0101, XOR

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; asynchronous, active-high
instr  in  32  instruction word from instruction memory
imem_ready  in  1  instr valid this cycle
dmem_ready  in  1  data access completes this cycle
zero  in  1  ALU zero flag
alu_op  out  4  ALU operation code
alu_src  out  1  1 = ALU op2 is the immediate
load_instr  out  1  IR / PC-hold capture strobe
mem_read  out  1  data memory read request
mem_write  out  1  data memory write request
mem_to_reg  out  1  writeback selects memory data
reg_write  out  1  register file write enable
pc_update  out  1  PC register load enable
pc_src  out  1  1 = branch target, 0 = PC+4
illegal  out  1  one-cycle pulse in EX for an unsupported instruction

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4 (3-bit register). Internal 32-bit IR.
- Reset (async): state <= IF, IR <= 0. While in reset and immediately after, outputs are: load_instr=1, alu_op=ALU_ADD, all others 0. IR does not load while rst=1.
- IF:
  - load_instr=1.
  - When imem_ready=1, IR <= instr and go to ID; otherwise stay in IF.
- ID: single cycle, go to EX.
- EX: alu_op and alu_src are decoded from IR; in all other states alu_op=ALU_ADD and alu_src=0.
  - R-type (opcode 0110011), alu_src=0. Decode by funct3: 000 gives ADD when IR[30]=0, SUB when IR[30]=1; 111 AND; 110 OR; 100 XOR; 010 SLT; 001 SLL; 101 gives SRA when IR[30]=1, else SRL. Next state WB.
  - I-type ALU (opcode 0010011), alu_src=1. Same funct3 map, except 000 is always ADD; 101 uses IR[30] for SRA/SRL. Next state WB.
  - LW (0000011, funct3 010) and SW (0100011, funct3 010): ADD, alu_src=1. Next state MEM.
  - BEQ (1100011, funct3 000): SUB, alu_src=0, pc_update=1, pc_src=zero. Next state IF.
  - Any other opcode/funct3 combination (including funct3 011 sltu): alu_op=ALU_ADD, illegal=1, pc_update=1, pc_src=0, no register or memory write. Next state IF.
- MEM:
  - LW: mem_read=1 until dmem_ready=1, then go to WB.
  - SW: mem_write=1 until dmem_ready=1. In the dmem_ready cycle also assert pc_update=1 (pc_src=0), then go to IF.
  - A request stays asserted and stable while waiting.
- WB:
  - reg_write=1 and pc_update=1 (pc_src=0).
  - mem_to_reg=1 for LW only.
  - Next state IF.
- Exactly one pc_update pulse per instruction. No write enable is ever asserted outside its single designated cycle.
- Unencoded state values 5–7: go to IF with all outputs as in reset.
- Reset mid-instruction (e.g. during an MEM wait): abandon the instruction immediately; no pending write completes.
- Cycle counts with zero wait states:
  - R/I: 4 cycles (IF, ID, EX, WB).
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ / illegal: 3 cycles.

Test Plan:
- Reset then instr=0x002081B3 (add), imem/dmem_ready=1 -> states IF,ID,EX,WB; EX alu_op=0010, alu_src=0; WB reg_write=1, pc_update=1; then back in IF.
- instr=0x402081B3 (sub) -> EX alu_op=0110. instr=0x4030D213 (srai) -> EX alu_op=1010, alu_src=1.
- instr=0x0080A283 (lw) with dmem_ready low for 3 cycles -> mem_read=1 held for 4 MEM cycles; WB mem_to_reg=1, reg_write=1; 8 cycles total.
- instr=0x0050A423 (sw) -> MEM mem_write=1 with pc_update=1 in the same cycle; reg_write never 1; 4 cycles.
- instr=0x00208463 (beq): with zero=1 -> EX pc_update=1, pc_src=1; with zero=0 -> pc_src=0; 3 cycles each.
- instr=0x0000000B (unsupported opcode) -> illegal=1 in EX, pc_update=1, no writes. Separately, assert rst during an LW MEM wait -> mem_read drops immediately, state=IF, load_instr=1.
